// File: rtl/count_nb.sv
// N-bit up/down counter with parallel load, programmable terminal value (modulo MAXV+1),
// wrap or saturate boundary handling, lookahead carry/borrow and a registered terminal-count pulse.
module count_nb #(
  parameter int W    = 4,
  parameter int MAXV = 2**W-1,
  parameter bit SAT  = 1'b0
) (
  input  logic         CLK,
  input  logic         Clr,
  input  logic         LOAD,
  input  logic         E,
  input  logic         D,
  input  logic [W-1:0] IN,
  output logic [W-1:0] Q,
  output logic         C,
  output logic         TC,
  output logic         EQZ,
  output logic         EQM
);

  localparam logic [W-1:0] MAXQ = W'(MAXV);

  if (W < 1 || MAXV < 1 || longint'(MAXV) > ((longint'(1) << W) - 1)) begin : g_param_chk
    $error("count_nb: MAXV=%0d out of range for W=%0d", MAXV, W);
  end

  // Load values above the terminal count clamp to it, so Q can never exceed MAXV.
  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
    return (v > MAXQ) ? MAXQ : v;
  endfunction

  logic         bnd;
  logic [W-1:0] q_nxt;
  logic         tc_nxt;

  assign EQZ = (Q == '0);
  assign EQM = (Q == MAXQ);
  assign bnd = D ? EQZ : EQM;

  // Gated by Clr so a cascade sees no carry while the slice is held in reset.
  assign C = Clr & E & ~LOAD & bnd;

  always_comb begin
    q_nxt  = Q;
    tc_nxt = 1'b0;
    if (LOAD) begin
      q_nxt = clamp_load(IN);
    end else if (E) begin
      if (bnd) begin
        tc_nxt = 1'b1;
        if (!SAT) q_nxt = D ? MAXQ : '0;
      end else begin
        q_nxt = D ? (Q - W'(1)) : (Q + W'(1));
      end
    end
  end

  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      Q  <= '0;
      TC <= 1'b0;
    end else begin
      Q  <= q_nxt;
      TC <= tc_nxt;
    end
  end

endmodule
